// File: rtl/mux_4to1.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mux_4to1                                                               |
// | 4-lane selector with a combinational output and a registered copy.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] D,
  input  logic [1:0]         S,
  input  logic               en,
  output logic [WIDTH-1:0]   Y,
  output logic [3:0]         sel_onehot,
  output logic [WIDTH-1:0]   Y_q,
  output logic               valid_q
);

  logic [WIDTH-1:0] w_lane [4];
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_valid_q;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_lane[i] = D[i*WIDTH +: WIDTH];
  end

  // Unknown select drives X rather than falling back to any lane.
  always_comb begin
    w_y = 'x;
    case (S)
      2'b00:   w_y = w_lane[0];
      2'b01:   w_y = w_lane[1];
      2'b10:   w_y = w_lane[2];
      2'b11:   w_y = w_lane[3];
      default: w_y = 'x;
    endcase
  end

  assign Y          = w_y;
  assign sel_onehot = 4'b0001 << S;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q     <= '0;
      r_valid_q <= 1'b0;
    end else if (en) begin
      r_y_q     <= w_y;
      r_valid_q <= 1'b1;
    end else begin
      r_valid_q <= 1'b0;
    end
  end

  assign Y_q     = r_y_q;
  assign valid_q = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1.sv
`default_nettype none
// Directed testbench for mux_4to1: WIDTH=1 and WIDTH=8 instances share control.
module tb_mux_4to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  S;
  logic        en;
  logic [3:0]  d1;
  logic [31:0] d8;
  logic        y1, y1_q, v1_q;
  logic [3:0]  oh1;
  logic [7:0]  y8, y8_q;
  logic [3:0]  oh8;
  logic        v8_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .D(d1), .S(S), .en(en),
    .Y(y1), .sel_onehot(oh1), .Y_q(y1_q), .valid_q(v1_q)
  );

  mux_4to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .D(d8), .S(S), .en(en),
    .Y(y8), .sel_onehot(oh8), .Y_q(y8_q), .valid_q(v8_q)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       exp_y1 [4];
    logic [3:0] exp_oh [4];
    logic [7:0] exp_y8 [4];
    exp_y1 = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_y8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    rst_n = 1'b0;
    en    = 1'b0;
    S     = 2'b00;
    d1    = 4'b1010;
    d8    = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    #1;
    check("reset_yq",    {7'd0, y1_q}, 8'h00);
    check("reset_valid", {7'd0, v1_q}, 8'h00);
    check("reset_y8q",   y8_q,          8'h00);

    // Combinational sweep while still in reset: Y must be live.
    for (int i = 0; i < 4; i++) begin
      S = 2'(i);
      #20;
      check($sformatf("comb_y1_s%0d", i),  {7'd0, y1}, {7'd0, exp_y1[i]});
      check($sformatf("comb_oh_s%0d", i),  {4'd0, oh1}, {4'd0, exp_oh[i]});
      check($sformatf("comb_y8_s%0d", i),  y8,          exp_y8[i]);
    end

    S  = 2'b01;
    d8 = {8'hDD, 8'hCC, 8'h5A, 8'hAA};
    #0 #0;
    check("comb_y8_dchange", y8, 8'h5A);
    d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

    // Single capture then hold.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    S     = 2'b01;
    @(posedge clk); #1;
    check("cap_yq",    {7'd0, y1_q}, 8'h01);
    check("cap_valid", {7'd0, v1_q}, 8'h01);
    check("cap_y8q",   y8_q,          8'hBB);
    @(negedge clk);
    en = 1'b0;
    S  = 2'b00;
    @(posedge clk); #1;
    check("hold_yq",    {7'd0, y1_q}, 8'h01);
    check("hold_valid", {7'd0, v1_q}, 8'h00);
    check("hold_y8q",   y8_q,          8'hBB);

    // Continuous enable: Y_q one cycle behind S.
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      S = 2'(i);
      @(posedge clk); #1;
      check($sformatf("cont_yq_%0d", i),    {7'd0, y1_q}, {7'd0, exp_y1[i]});
      check($sformatf("cont_valid_%0d", i), {7'd0, v1_q}, 8'h01);
      check($sformatf("cont_y8q_%0d", i),   y8_q,          exp_y8[i]);
    end

    // Async reset mid-cycle; between-edge changes must not disturb Y_q first.
    S = 2'b00;
    #2;
    check("between_edges_yq", {7'd0, y1_q}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("async_yq",    {7'd0, y1_q}, 8'h00);
    check("async_valid", {7'd0, v1_q}, 8'h00);
    check("async_y8q",   y8_q,          8'h00);
    S = 2'b10;
    #1;
    check("rst_comb_y8", y8,          8'hCC);
    S = 2'b01;
    #1;
    check("rst_comb_y1", {7'd0, y1}, 8'h01);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    S     = 2'b11;
    @(posedge clk); #1;
    check("release_yq",    {7'd0, y1_q}, 8'h01);
    check("release_valid", {7'd0, v1_q}, 8'h01);
    check("release_y8q",   y8_q,          8'hDD);

    // Reset held with enable high: no capture may occur.
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S = 2'(i + 1);
      @(posedge clk); #1;
      check($sformatf("rst_en_yq_%0d", i),    {7'd0, y1_q}, 8'h00);
      check($sformatf("rst_en_valid_%0d", i), {7'd0, v1_q}, 8'h00);
      check($sformatf("rst_en_y8q_%0d", i),   y8_q,          8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- 4-input, 1-output selector, one input lane per select code.
- Provides a zero-latency combinational output Y and a registered copy Y_q with a valid flag for timing-closed downstream paths.
- Used wherever one of four equal-width data sources must be steered to a single consumer.

Parameters:
- WIDTH, default 1: bit width of each data lane and of the outputs.

Ports:
- clk  input  1  rising-edge clock for the registered path
- rst_n  input  1  asynchronous, active-low reset
- D  input  4*WIDTH  packed data lanes; lane i = D[i*WIDTH +: WIDTH], lane 0 in the LSBs
- S  input  2  lane select
- en  input  1  capture enable for the registered path
- Y  output  WIDTH  combinational selected lane
- sel_onehot  output  4  combinational one-hot decode of S
- Y_q  output  WIDTH  registered selected lane
- valid_q  output  1  high for the cycle after a capture

Behaviour:
- Combinational path:
  - Y = lane S of D: S=00 -> lane0, 01 -> lane1, 10 -> lane2, 11 -> lane3.
  - Zero latency; Y follows any change on D or S within the same delta/settle.
  - Y does not depend on clk, rst_n or en, and is valid during reset.
- sel_onehot = 4'b0001 << S. It is always exactly one-hot.
- No X-propagation masking. If S contains X/Z, Y and sel_onehot are X in simulation. No default lane is substituted.
- Registered path, on each rising clk edge with rst_n=1:
  - if en=1: Y_q <= Y (the value at that edge) and valid_q <= 1.
  - if en=0: Y_q holds its value and valid_q <= 0.
- Latency: Y_q reflects the D/S present at the capturing edge, one cycle after the edge.
- Reset:
  - rst_n=0 immediately (asynchronously) forces Y_q=0 and valid_q=0, independent of clk.
  - Release is sampled at the next rising edge. The first capture can occur on the first edge with rst_n=1 and en=1.
- Reset mid-operation: asserting rst_n while en=1 clears Y_q and valid_q at once. No capture occurs while rst_n=0.
- Back-to-back captures: en held high captures every cycle, and valid_q stays high continuously.
- Changing S or D between edges does not affect Y_q until the next enabled edge.
- Width rule: all lanes and outputs are WIDTH bits. There is no extension or truncation.

Test Plan:
- Combinational lane sweep: WIDTH=1, D=4'b1010, S=00,01,10,11, 20 ns each -> Y=0,1,0,1 and sel_onehot=0001,0010,0100,1000.
- Multi-bit lanes: WIDTH=8, D={8'hDD,8'hCC,8'hBB,8'hAA}, S swept 00..11 -> Y=AA,BB,CC,DD. Changing D with S fixed updates Y in the same timestep.
- Registered capture: en=1, S=01, D=4'b1010 at edge N -> Y_q=1 and valid_q=1 after edge N. Then en=0 at edge N+1 with S=00 -> Y_q stays 1 and valid_q=0.
- Continuous enable: en=1, S stepping 00,01,10,11 on successive edges, D=4'b1010 -> Y_q sequence 0,1,0,1 one cycle behind S, with valid_q constantly 1.
- Async reset: Y_q=1, valid_q=1, then rst_n dropped mid-cycle -> both 0 before the next clk edge. Y still tracks D/S during reset. After release with en=1 -> capture on the first edge.
- Reset while enabled: rst_n=0 with en=1 for 3 edges -> Y_q=0 and valid_q=0 throughout.
